// File: rtl/sram_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM states, default
// base address and the external SRAM data width.
package sram_controller_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      WR_LO = 3'd3,
      WR_HI = 3'd4,
      DONE  = 3'd5
   } ctrlState_t;

   localparam int unsigned DEFAULT_BASE_ADDR = 1024;
   localparam int unsigned SRAM_DW           = 16;

endpackage

// File: rtl/sram_controller_access_timer.sv
// Loadable down-counter timing one half-word SRAM access; flags the last cycle
// of the access and the cycle just before it.
module access_timer #(
   parameter int unsigned CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic last,
   output logic nearLast
);

   localparam int unsigned CW = $clog2(CYCLES);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= CW'(CYCLES - 1);
      end else if (count != '0) begin
         count <= count - CW'(1);
      end
   end

   assign last     = (count == '0);
   assign nearLast = (count == CW'(1));

endmodule

// File: rtl/sram_controller.sv
// MEM-stage data-memory responder: splits 32-bit loads/stores into two
// half-word accesses on a 16-bit asynchronous SRAM, stalling via ready.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int unsigned BASE_ADDR     = DEFAULT_BASE_ADDR,
   parameter int unsigned SRAM_AW       = 18,
   parameter int unsigned ACCESS_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                memREn,
   input  logic                memWEn,
   input  logic [31:0]         address,
   input  logic [31:0]         writeData,
   output logic [31:0]         readData,
   output logic                ready,
   output logic [SRAM_AW-1:0]  sramAddr,
   output logic [SRAM_DW-1:0]  sramDqOut,
   input  logic [SRAM_DW-1:0]  sramDqIn,
   output logic                sramDqOe,
   output logic                sramWeN
);

   ctrlState_t                 state;
   logic [31:0]                offset;
   logic [SRAM_AW-2:0]         wordIdx;
   logic [SRAM_AW-2:0]         capIdx;
   logic [SRAM_DW-1:0]         capHi;
   logic                       loadTimer;
   logic                       timerLast;
   logic                       timerNearLast;
   logic                       unusedAddrBits;

   assign offset         = address - 32'(BASE_ADDR);
   assign wordIdx        = offset[SRAM_AW:2];
   assign unusedAddrBits = ^{offset[31:SRAM_AW+1], offset[1:0]};

   assign ready = ((state == IDLE) && !memREn && !memWEn) || (state == DONE);

   // Reload on request acceptance and on every LO->HI hand-over.
   assign loadTimer = ((state == IDLE) && (memREn || memWEn)) ||
                      (((state == RD_LO) || (state == WR_LO)) && timerLast);

   access_timer #(.CYCLES(ACCESS_CYCLES)) timer (
      .clk      (clk),
      .rst      (rst),
      .load     (loadTimer),
      .last     (timerLast),
      .nearLast (timerNearLast)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         capIdx    <= '0;
         capHi     <= '0;
         readData  <= '0;
         sramAddr  <= '0;
         sramDqOut <= '0;
         sramDqOe  <= 1'b0;
         sramWeN   <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (memREn) begin
                  state    <= RD_LO;
                  capIdx   <= wordIdx;
                  sramAddr <= {wordIdx, 1'b0};
               end else if (memWEn) begin
                  state     <= WR_LO;
                  capIdx    <= wordIdx;
                  capHi     <= writeData[31:16];
                  sramAddr  <= {wordIdx, 1'b0};
                  sramDqOut <= writeData[15:0];
                  sramDqOe  <= 1'b1;
                  sramWeN   <= 1'b0;
               end
            end
            RD_LO: begin
               if (timerLast) begin
                  readData[15:0] <= sramDqIn;
                  sramAddr       <= {capIdx, 1'b1};
                  state          <= RD_HI;
               end
            end
            RD_HI: begin
               if (timerLast) begin
                  readData[31:16] <= sramDqIn;
                  state           <= DONE;
               end
            end
            // WeN is registered, so it is released one edge early to leave the
            // final cycle of each half as address/data hold.
            WR_LO: begin
               if (timerLast) begin
                  sramAddr  <= {capIdx, 1'b1};
                  sramDqOut <= capHi;
                  sramWeN   <= 1'b0;
                  state     <= WR_HI;
               end else if (timerNearLast) begin
                  sramWeN <= 1'b1;
               end
            end
            WR_HI: begin
               if (timerLast) begin
                  sramDqOe <= 1'b0;
                  state    <= DONE;
               end else if (timerNearLast) begin
                  sramWeN <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               sramDqOe <= 1'b0;
               sramWeN  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 16-bit SRAM model.
module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        memREn;
   logic        memWEn;
   logic [31:0] address;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        ready;
   logic [17:0] sramAddr;
   logic [15:0] sramDqOut;
   logic [15:0] sramDqIn;
   logic        sramDqOe;
   logic        sramWeN;

   int testsRun = 0;
   int testsFailed = 0;

   logic [15:0] mem [0:1023];
   int          wePulses = 0;
   logic        prevWeN = 1'b1;
   int          wrN = 0;
   logic [17:0] wrAddr [0:63];
   logic [15:0] wrDat  [0:63];

   always #5 clk = ~clk;

   sram_controller #(
      .BASE_ADDR     (1024),
      .SRAM_AW       (18),
      .ACCESS_CYCLES (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .memREn    (memREn),
      .memWEn    (memWEn),
      .address   (address),
      .writeData (writeData),
      .readData  (readData),
      .ready     (ready),
      .sramAddr  (sramAddr),
      .sramDqOut (sramDqOut),
      .sramDqIn  (sramDqIn),
      .sramDqOe  (sramDqOe),
      .sramWeN   (sramWeN)
   );

   assign sramDqIn = mem[sramAddr[9:0]];

   always @(posedge clk) begin
      if (!sramWeN && sramDqOe) begin
         mem[sramAddr[9:0]] <= sramDqOut;
         if (wrN < 64) begin
            wrAddr[wrN] = sramAddr;
            wrDat[wrN]  = sramDqOut;
         end
         wrN = wrN + 1;
      end
      if (!sramWeN && prevWeN) wePulses = wePulses + 1;
      prevWeN = sramWeN;
   end

   // Drives one request and counts ready-low cycles until DONE (bounded).
   // Leaves the request asserted through DONE; the caller decides what follows.
   task automatic doAccess(input logic rEn, input logic wEn, input logic [31:0] addr,
                           input logic [31:0] data, output int lowCycles, output logic gotDone);
      @(posedge clk); #1;
      memREn = rEn; memWEn = wEn; address = addr; writeData = data;
      lowCycles = 0;
      gotDone = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ready) begin
            gotDone = 1'b1;
            break;
         end
         lowCycles++;
      end
   endtask

   task automatic dropRequest();
      @(posedge clk); #1;
      memREn = 1'b0; memWEn = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; memREn = 1'b0; memWEn = 1'b0; address = '0; writeData = '0;
      repeat (2) @(negedge clk);
      testsRun++;
      if (ready !== 1'b1 || sramWeN !== 1'b1 || sramDqOe !== 1'b0 ||
          readData !== 32'h0 || sramAddr !== 18'h0) begin
         testsFailed++;
         $display("FAIL reset_state: ready=%b weN=%b oe=%b readData=%h addr=%h, required 1 1 0 0 0",
                  ready, sramWeN, sramDqOe, readData, sramAddr);
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      testsRun++;
      if (ready !== 1'b1) begin
         testsFailed++;
         $display("FAIL reset_idle_ready: ready=%b, required 1", ready);
      end
   endtask

   task automatic test_store();
      int   low;
      logic done;
      int   n0;
      int   p0;
      n0 = wrN; p0 = wePulses;
      doAccess(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, low, done);
      testsRun++;
      if (!done || low != 5) begin
         testsFailed++;
         $display("FAIL store_ready_low: done=%b low=%0d, required 1 and 5", done, low);
      end
      dropRequest();
      testsRun++;
      if (wrN - n0 != 2 || wePulses - p0 != 2) begin
         testsFailed++;
         $display("FAIL store_strobes: writes=%0d pulses=%0d, required 2 and 2", wrN - n0, wePulses - p0);
      end else begin
         testsRun++;
         if (wrAddr[n0] !== 18'd2 || wrDat[n0] !== 16'hBEEF ||
             wrAddr[n0+1] !== 18'd3 || wrDat[n0+1] !== 16'hDEAD) begin
            testsFailed++;
            $display("FAIL store_halves: %h=%h %h=%h, required 2=beef 3=dead",
                     wrAddr[n0], wrDat[n0], wrAddr[n0+1], wrDat[n0+1]);
         end
      end
      @(negedge clk);
      testsRun++;
      if (ready !== 1'b1 || sramDqOe !== 1'b0 || sramWeN !== 1'b1) begin
         testsFailed++;
         $display("FAIL store_idle: ready=%b oe=%b weN=%b, required 1 0 1", ready, sramDqOe, sramWeN);
      end
   endtask

   task automatic test_load();
      int   low;
      logic done;
      int   p0;
      p0 = wePulses;
      doAccess(1'b1, 1'b0, 32'd1028, 32'h0, low, done);
      testsRun++;
      if (!done || low != 5 || readData !== 32'hDEADBEEF) begin
         testsFailed++;
         $display("FAIL load_done: done=%b low=%0d readData=%h, required 1 5 deadbeef", done, low, readData);
      end
      dropRequest();
      address = 32'd0;
      repeat (2) @(negedge clk);
      testsRun++;
      if (readData !== 32'hDEADBEEF || wePulses != p0) begin
         testsFailed++;
         $display("FAIL load_hold: readData=%h pulses=%0d, required deadbeef 0", readData, wePulses - p0);
      end
      // Low address bits are ignored: 1031 maps to the same word as 1028.
      mem[2] = 16'h1111;
      doAccess(1'b1, 1'b0, 32'd1031, 32'h0, low, done);
      testsRun++;
      if (!done || readData !== 32'hDEAD1111) begin
         testsFailed++;
         $display("FAIL load_unaligned: readData=%h, required dead1111", readData);
      end
      dropRequest();
      mem[2] = 16'hBEEF;
   endtask

   task automatic test_back_to_back();
      int   low;
      logic done;
      int   p0;
      p0 = wePulses;
      doAccess(1'b0, 1'b1, 32'd1032, 32'h12345678, low, done);
      testsRun++;
      if (!done || low != 5) begin
         testsFailed++;
         $display("FAIL b2b_store: done=%b low=%0d, required 1 5", done, low);
      end
      // Load presented in the IDLE cycle right after DONE; must be accepted there.
      @(posedge clk); #1;
      memWEn = 1'b0; memREn = 1'b1; address = 32'd1032;
      @(negedge clk);
      testsRun++;
      if (ready !== 1'b0) begin
         testsFailed++;
         $display("FAIL b2b_idle_ready: ready=%b, required 0", ready);
      end
      @(negedge clk);
      testsRun++;
      if (sramAddr !== 18'd4 || sramDqOe !== 1'b0) begin
         testsFailed++;
         $display("FAIL b2b_read_start: addr=%h oe=%b, required 4 0", sramAddr, sramDqOe);
      end
      low = 0; done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (ready) begin
            done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      testsRun++;
      if (!done || readData !== 32'h12345678 || wePulses - p0 != 2) begin
         testsFailed++;
         $display("FAIL b2b_load: done=%b readData=%h pulses=%0d, required 1 12345678 2",
                  done, readData, wePulses - p0);
      end
      dropRequest();
   endtask

   task automatic test_reset_mid_access();
      mem[7] = 16'h0000;
      @(posedge clk); #1;
      memWEn = 1'b1; address = 32'd1036; writeData = 32'hCAFEF00D;
      repeat (3) @(posedge clk);
      #1;
      testsRun++;
      if (sramAddr !== 18'd7 || sramWeN !== 1'b0) begin
         testsFailed++;
         $display("FAIL midrst_in_wrhi: addr=%h weN=%b, required 7 0", sramAddr, sramWeN);
      end
      rst = 1'b0; memWEn = 1'b0;
      #1;
      testsRun++;
      if (sramWeN !== 1'b1 || sramDqOe !== 1'b0 || ready !== 1'b1 || sramAddr !== 18'd0) begin
         testsFailed++;
         $display("FAIL midrst_outputs: weN=%b oe=%b ready=%b addr=%h, required 1 0 1 0",
                  sramWeN, sramDqOe, ready, sramAddr);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      testsRun++;
      if (mem[7] !== 16'h0000 || mem[6] !== 16'hF00D || ready !== 1'b1) begin
         testsFailed++;
         $display("FAIL midrst_memory: mem7=%h mem6=%h ready=%b, required 0000 f00d 1", mem[7], mem[6], ready);
      end
   endtask

   task automatic test_conflict();
      int   low;
      logic done;
      int   p0;
      int   n0;
      p0 = wePulses; n0 = wrN;
      doAccess(1'b1, 1'b1, 32'd1028, 32'h55555555, low, done);
      testsRun++;
      if (!done || low != 5 || readData !== 32'hDEADBEEF || wePulses != p0 || wrN != n0) begin
         testsFailed++;
         $display("FAIL conflict: done=%b low=%0d readData=%h pulses=%0d, required 1 5 deadbeef 0",
                  done, low, readData, wePulses - p0);
      end
      dropRequest();
      @(negedge clk);
      testsRun++;
      if (mem[2] !== 16'hBEEF || mem[3] !== 16'hDEAD) begin
         testsFailed++;
         $display("FAIL conflict_memory: mem2=%h mem3=%h, required beef dead", mem[2], mem[3]);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      test_reset();
      test_store();
      test_load();
      test_back_to_back();
      test_reset_mid_access();
      test_conflict();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
